// File: rtl/noc_inject_pkg.sv
// Shared sizing constants and FSM state encoding for the packet injection scheduler.
package noc_inject_pkg;

    localparam int NODES = 49;
    localparam int PKT_W = 13;
    localparam int IDX_W = 6;
    localparam int TMO   = 255;
    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SEND = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/onehot_dec.sv
// Router index to one-hot valid decoder; all outputs low when not enabled.
module onehot_dec #(
    parameter int IDX_W = noc_inject_pkg::IDX_W,
    parameter int NODES = noc_inject_pkg::NODES
) (
    input  logic             en,
    input  logic [IDX_W-1:0] idx,
    output logic [NODES-1:0] onehot
);

    // NOTE: every bit is assigned on every pass, so no latch is inferred.
    always_comb begin
        for (int i = 0; i < NODES; i++) begin
            onehot[i] = en && (idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/inject_scheduler_49.sv
// Injects one packet, or a sweep of one packet per router, into the NoC with ack timeout.
module inject_scheduler_49 #(
    parameter int NODES = noc_inject_pkg::NODES,
    parameter int PKT_W = noc_inject_pkg::PKT_W,
    parameter int IDX_W = noc_inject_pkg::IDX_W,
    parameter int TMO   = noc_inject_pkg::TMO
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [IDX_W-1:0] cfg_router,
    input  logic [PKT_W-2:0] cfg_data,
    input  logic [NODES-1:0] pkt_ack,
    output logic [PKT_W-1:0] pkt_out,
    output logic [NODES-1:0] pkt_valid,
    output logic [IDX_W-1:0] cur_router,
    output logic             busy,
    output logic             done,
    output logic             err_tmo,
    output logic             err_cfg
);

    import noc_inject_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NODES - 1);
    localparam logic [CNT_W:0]   TMO_LIM  = (CNT_W + 1)'(TMO);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] start_idx_q, start_idx_d;
    logic [PKT_W-2:0] data_q, data_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_tmo_q, err_tmo_d;
    logic             err_cfg_q, err_cfg_d;

    logic             cfg_ok;
    logic             ack_hit;
    logic             tmo_hit;
    logic             send_en;
    logic [IDX_W-1:0] idx_inc;

    assign cfg_ok  = (cfg_router <= LAST_IDX);
    // Only the ack bit of the router currently being driven can match a valid bit.
    assign ack_hit = |(pkt_ack & pkt_valid);
    assign tmo_hit = (({1'b0, cnt_q} + (CNT_W + 1)'(1)) == TMO_LIM);
    assign idx_inc = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;

    // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start && cfg_ok) state_d = ST_LOAD;
            ST_LOAD: state_d = ST_SEND;
            ST_SEND: if (ack_hit || tmo_hit) state_d = mode_q ? ST_GAP : ST_DONE;
            ST_GAP:  state_d = (idx_inc == start_idx_q) ? ST_DONE : ST_LOAD;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q       <= '0;
            start_idx_q <= '0;
            data_q      <= '0;
            mode_q      <= 1'b0;
            cnt_q       <= '0;
            err_tmo_q   <= 1'b0;
            err_cfg_q   <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            start_idx_q <= start_idx_d;
            data_q      <= data_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            err_tmo_q   <= err_tmo_d;
            err_cfg_q   <= err_cfg_d;
        end
    end

    always_comb begin
        idx_d       = idx_q;
        start_idx_d = start_idx_q;
        data_d      = data_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        err_tmo_d   = err_tmo_q;
        err_cfg_d   = err_cfg_q;
        case (state_q)
            ST_IDLE: begin
                if (start && cfg_ok) begin
                    idx_d       = cfg_router;
                    start_idx_d = cfg_router;
                    data_d      = cfg_data;
                    mode_d      = mode;
                    err_tmo_d   = 1'b0;
                    err_cfg_d   = 1'b0;
                end else if (start) begin
                    err_cfg_d = 1'b1;
                end
            end
            ST_LOAD: cnt_d = '0;
            ST_SEND: begin
                // An ack on the final timeout cycle takes priority over the error.
                if (!ack_hit) begin
                    cnt_d = cnt_q + 1'b1;
                    if (tmo_hit) err_tmo_d = 1'b1;
                end
            end
            ST_GAP:  idx_d = idx_inc;
            default: ;
        endcase
    end

    always_comb begin
        send_en = (state_q == ST_SEND);
        busy    = (state_q != ST_IDLE);
        done    = (state_q == ST_DONE);
        pkt_out = ((state_q == ST_LOAD) || send_en) ? {1'b1, data_q} : '0;
    end

    assign cur_router = idx_q;
    assign err_tmo    = err_tmo_q;
    assign err_cfg    = err_cfg_q;

    onehot_dec #(
        .IDX_W (IDX_W),
        .NODES (NODES)
    ) u_dec (
        .en     (send_en),
        .idx    (idx_q),
        .onehot (pkt_valid)
    );

endmodule

// File: tb/tb_inject_scheduler_49.sv
// Directed self-checking bench for inject_scheduler_49; inputs driven and outputs sampled on negedge.
module tb_inject_scheduler_49;

    localparam int NODES = 49;
    localparam int PKT_W = 13;
    localparam int IDX_W = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             mode;
    logic [IDX_W-1:0] cfg_router;
    logic [PKT_W-2:0] cfg_data;
    logic [NODES-1:0] pkt_ack;
    logic [PKT_W-1:0] pkt_out;
    logic [NODES-1:0] pkt_valid;
    logic [IDX_W-1:0] cur_router;
    logic             busy;
    logic             done;
    logic             err_tmo;
    logic             err_cfg;

    int total = 0;
    int bad   = 0;

    inject_scheduler_49 dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .cfg_router (cfg_router),
        .cfg_data   (cfg_data),
        .pkt_ack    (pkt_ack),
        .pkt_out    (pkt_out),
        .pkt_valid  (pkt_valid),
        .cur_router (cur_router),
        .busy       (busy),
        .done       (done),
        .err_tmo    (err_tmo),
        .err_cfg    (err_cfg)
    );

    always #5 clk = ~clk;

    function automatic logic [NODES-1:0] oh(input int i);
        logic [NODES-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Leaves the bench at the negedge of the LOAD cycle when the start is accepted.
    task automatic do_start(input logic m, input logic [IDX_W-1:0] r, input logic [PKT_W-2:0] d);
        start      = 1'b1;
        mode       = m;
        cfg_router = r;
        cfg_data   = d;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (pkt_out !== '0 || pkt_valid !== '0 || busy !== 1'b0 || done !== 1'b0 ||
            err_tmo !== 1'b0 || err_cfg !== 1'b0 || cur_router !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got out=%h valid=%h busy=%b done=%b tmo=%b cfg=%b cur=%0d, want all 0",
                     pkt_out, pkt_valid, busy, done, err_tmo, err_cfg, cur_router);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_single();
        pkt_ack = '0;
        do_start(1'b0, 6'd5, 12'h02A);
        total++;
        if (pkt_valid !== '0 || pkt_out !== 13'h102A || busy !== 1'b1) begin
            bad++;
            $display("FAIL single_load: got valid=%h out=%h busy=%b want 0/102a/1", pkt_valid, pkt_out, busy);
        end
        @(negedge clk);
        total++;
        if (pkt_valid !== oh(5) || pkt_out !== 13'h102A || cur_router !== 6'd5) begin
            bad++;
            $display("FAIL single_valid_t2: got valid=%h out=%h cur=%0d want %h/102a/5",
                     pkt_valid, pkt_out, cur_router, oh(5));
        end
        repeat (3) @(negedge clk);
        total++;
        if (pkt_valid !== oh(5) || pkt_out !== 13'h102A || done !== 1'b0) begin
            bad++;
            $display("FAIL single_hold: got valid=%h out=%h done=%b", pkt_valid, pkt_out, done);
        end
        pkt_ack = oh(5);
        @(negedge clk);
        pkt_ack = '0;
        total++;
        if (done !== 1'b1 || pkt_valid !== '0 || err_tmo !== 1'b0) begin
            bad++;
            $display("FAIL single_done: got done=%b valid=%h tmo=%b want 1/0/0", done, pkt_valid, err_tmo);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || pkt_out !== '0) begin
            bad++;
            $display("FAIL single_idle: got done=%b busy=%b out=%h want 0/0/0", done, busy, pkt_out);
        end
    endtask

    task automatic test_sweep();
        int  n;
        int  exp_r;
        bit  got_done;
        bit  prev_v;
        n        = 0;
        got_done = 1'b0;
        prev_v   = 1'b0;
        pkt_ack  = '1;
        do_start(1'b1, 6'd47, 12'h155);
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (pkt_valid !== '0) begin
                exp_r = (47 + n) % NODES;
                total++;
                if (pkt_valid !== oh(exp_r) || cur_router !== IDX_W'(exp_r) ||
                    pkt_out !== 13'h1155 || prev_v) begin
                    bad++;
                    $display("FAIL sweep_pkt%0d: got valid=%h cur=%0d out=%h back2back=%b want router %0d out 1155",
                             n, pkt_valid, cur_router, pkt_out, prev_v, exp_r);
                end
                n++;
            end
            prev_v = (pkt_valid !== '0);
            if (done === 1'b1) begin
                got_done = 1'b1;
                break;
            end
        end
        pkt_ack = '0;
        total++;
        if (!got_done || n != NODES || cur_router !== 6'd47) begin
            bad++;
            $display("FAIL sweep_count: got done=%b packets=%0d cur=%0d want 1/49/47", got_done, n, cur_router);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int n;
        bit got_done;
        n        = 0;
        got_done = 1'b0;
        pkt_ack  = '0;
        do_start(1'b0, 6'd10, 12'hABC);
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got_done = 1'b1;
                break;
            end
            if (pkt_valid === oh(10)) n++;
        end
        total++;
        if (!got_done || n != 255 || err_tmo !== 1'b1) begin
            bad++;
            $display("FAIL timeout_run: got done=%b valid_cycles=%0d tmo=%b want 1/255/1", got_done, n, err_tmo);
        end
        @(negedge clk);
        total++;
        if (err_tmo !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL timeout_sticky: got tmo=%b busy=%b want 1/0", err_tmo, busy);
        end
    endtask

    task automatic test_ack();
        do_start(1'b0, 6'd7, 12'h001);
        total++;
        if (err_tmo !== 1'b0) begin
            bad++;
            $display("FAIL ack_tmo_clear: got tmo=%b want 0", err_tmo);
        end
        @(negedge clk);
        pkt_ack = oh(3);
        repeat (5) @(negedge clk);
        total++;
        if (pkt_valid !== oh(7) || done !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL ack_wrong_bit: got valid=%h done=%b busy=%b want %h/0/1", pkt_valid, done, busy, oh(7));
        end
        pkt_ack = oh(7);
        @(negedge clk);
        pkt_ack = '0;
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL ack_right_bit: got done=%b want 1", done);
        end
        @(negedge clk);
        do_start(1'b0, 6'd20, 12'h3FF);
        @(negedge clk);
        repeat (254) @(negedge clk);
        total++;
        if (pkt_valid !== oh(20) || err_tmo !== 1'b0) begin
            bad++;
            $display("FAIL ack_last_send: got valid=%h tmo=%b want %h/0", pkt_valid, err_tmo, oh(20));
        end
        pkt_ack = oh(20);
        @(negedge clk);
        pkt_ack = '0;
        total++;
        if (done !== 1'b1 || err_tmo !== 1'b0) begin
            bad++;
            $display("FAIL ack_vs_timeout: got done=%b tmo=%b want 1/0", done, err_tmo);
        end
        @(negedge clk);
    endtask

    task automatic test_range_ignore();
        do_start(1'b0, 6'd49, 12'h123);
        total++;
        if (err_cfg !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL range_err: got cfg=%b busy=%b want 1/0", err_cfg, busy);
        end
        @(negedge clk);
        total++;
        if (err_cfg !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL range_sticky: got cfg=%b busy=%b want 1/0", err_cfg, busy);
        end
        do_start(1'b0, 6'd2, 12'h055);
        total++;
        if (err_cfg !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL range_clear: got cfg=%b busy=%b want 0/1", err_cfg, busy);
        end
        @(negedge clk);
        do_start(1'b1, 6'd9, 12'h000);
        total++;
        if (cur_router !== 6'd2 || pkt_out !== 13'h1055 || pkt_valid !== oh(2)) begin
            bad++;
            $display("FAIL busy_start_ignored: got cur=%0d out=%h valid=%h want 2/1055/%h",
                     cur_router, pkt_out, pkt_valid, oh(2));
        end
        pkt_ack = oh(2);
        @(negedge clk);
        pkt_ack = '0;
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL busy_start_mode: got done=%b want 1", done);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL range_end_idle: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_mid_reset();
        do_start(1'b0, 6'd30, 12'h777);
        @(negedge clk);
        total++;
        if (pkt_valid !== oh(30)) begin
            bad++;
            $display("FAIL midrst_send: got valid=%h want %h", pkt_valid, oh(30));
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (pkt_valid !== '0 || pkt_out !== '0 || busy !== 1'b0 || done !== 1'b0 || cur_router !== '0) begin
            bad++;
            $display("FAIL midrst_async: got valid=%h out=%h busy=%b done=%b cur=%0d want all 0",
                     pkt_valid, pkt_out, busy, done, cur_router);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || pkt_valid !== '0 || err_tmo !== 1'b0 || err_cfg !== 1'b0) begin
            bad++;
            $display("FAIL midrst_idle: got busy=%b valid=%h tmo=%b cfg=%b want 0", busy, pkt_valid, err_tmo, err_cfg);
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        mode       = 1'b0;
        cfg_router = '0;
        cfg_data   = '0;
        pkt_ack    = '0;
        test_reset();
        test_single();
        test_sweep();
        test_timeout();
        test_ack();
        test_range_ignore();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
